// File: rtl/fixed_absmax_block_quantizer_pkg.sv
// Shared helpers for the absmax block quantizer.
// Computes the block right-shift from the magnitude's leading-one position.
package fixed_absmax_block_quantizer_pkg;

  // Shift so the largest magnitude keeps OUT_WIDTH-1 significant bits plus sign.
  function automatic int calc_shift(input int msb, input int out_width);
    return (msb > out_width - 2) ? msb - (out_width - 2) : 0;
  endfunction

endpackage

// File: rtl/fixed_absmax_block_quantizer_lod.sv
// Leading-one detector: index of the highest set bit of i_value.
// An all-zero input reports index 0.
module fixed_leading_one_detector #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0]     i_value,
  output logic [IDX_WIDTH-1:0] o_msb
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_msb and no latch is inferred.
    o_msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_value[i]) o_msb = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/fixed_absmax_block_quantizer.sv
// Collects BLOCK_SIZE signed elements, derives a shared right-shift from the
// block's largest magnitude, then streams the saturated, shifted elements out.
module fixed_absmax_block_quantizer
  import fixed_absmax_block_quantizer_pkg::*;
#(
  parameter  int IN_WIDTH   = 16,
  parameter  int OUT_WIDTH  = 8,
  parameter  int BLOCK_SIZE = 4,
  localparam int EXP_WIDTH  = $clog2(IN_WIDTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic [EXP_WIDTH-1:0]        data_out_exp,
  output logic                        data_out_last,
  output logic                        data_out_valid,
  input  logic                        data_out_ready
);

  localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
  localparam int Q_MAX = (2 ** (OUT_WIDTH - 1)) - 1;
  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'(Q_MAX);
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = IN_WIDTH'(-Q_MAX);

  typedef enum logic [1:0] {COLLECT, SCALE, EMIT} state_t;

  state_t                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [IN_WIDTH-1:0]          r_absmax;
  logic signed [IN_WIDTH-1:0]   r_buf [BLOCK_SIZE];
  logic                         r_in_ready;
  logic                         r_valid;
  logic                         r_last;
  logic signed [OUT_WIDTH-1:0]  r_out;
  logic [EXP_WIDTH-1:0]         r_exp;

  logic                         w_in_fire;
  logic                         w_out_fire;
  logic [IN_WIDTH-1:0]          w_mag;
  logic [EXP_WIDTH-1:0]         w_msb;
  logic [EXP_WIDTH-1:0]         w_shift;
  logic [EXP_WIDTH-1:0]         w_sel_shift;
  logic [IDX_W-1:0]             w_next_idx;
  logic [IDX_W-1:0]             w_sel_idx;
  logic signed [IN_WIDTH-1:0]   w_shifted;
  logic signed [IN_WIDTH-1:0]   w_clamped;

  assign w_in_fire  = data_in_valid && r_in_ready;
  assign w_out_fire = r_valid && data_out_ready;

  // Unsigned magnitude; the most negative input maps to 2^(IN_WIDTH-1) without overflow.
  assign w_mag = data_in[IN_WIDTH-1] ? (~data_in + 1'b1) : data_in;

  fixed_leading_one_detector #(
    .WIDTH     (IN_WIDTH),
    .IDX_WIDTH (EXP_WIDTH)
  ) u_lod (
    .i_value (r_absmax),
    .o_msb   (w_msb)
  );

  assign w_shift    = EXP_WIDTH'(calc_shift(int'(w_msb), OUT_WIDTH));
  assign w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

  // The output register is loaded one element ahead: element 0 in SCALE, idx+1 on each EMIT handshake.
  assign w_sel_idx   = (r_state == SCALE) ? '0 : w_next_idx;
  assign w_sel_shift = (r_state == SCALE) ? w_shift : r_exp;
  assign w_shifted   = r_buf[w_sel_idx] >>> w_sel_shift;

  always_comb begin
    w_clamped = w_shifted;
    if (w_shifted > SAT_HI)      w_clamped = SAT_HI;
    else if (w_shifted < SAT_LO) w_clamped = SAT_LO;
  end

  // NOTE: element storage has no reset; contents are only read after being written in COLLECT.
  always_ff @(posedge clk) begin
    if (r_state == COLLECT && w_in_fire) r_buf[r_idx] <= data_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_idx      <= '0;
      r_absmax   <= '0;
      r_in_ready <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_out      <= '0;
      r_exp      <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            if (w_mag > r_absmax) r_absmax <= w_mag;
            if (r_idx == LAST_IDX) begin
              r_idx      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= SCALE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        SCALE: begin
          r_exp   <= w_shift;
          r_out   <= w_clamped[OUT_WIDTH-1:0];
          r_last  <= (BLOCK_SIZE == 1);
          r_valid <= 1'b1;
          r_state <= EMIT;
        end
        EMIT: begin
          if (w_out_fire) begin
            if (r_idx == LAST_IDX) begin
              r_state    <= COLLECT;
              r_idx      <= '0;
              r_absmax   <= '0;
              r_valid    <= 1'b0;
              r_last     <= 1'b0;
              r_in_ready <= 1'b1;
            end else begin
              r_idx  <= w_next_idx;
              r_out  <= w_clamped[OUT_WIDTH-1:0];
              r_last <= (w_next_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign data_in_ready  = r_in_ready;
  assign data_out       = r_out;
  assign data_out_exp   = r_exp;
  assign data_out_last  = r_last;
  assign data_out_valid = r_valid;

endmodule

// File: tb/tb_fixed_absmax_block_quantizer.sv
// Directed bench for fixed_absmax_block_quantizer (16-bit in, 8-bit out, blocks of 4).
// Expected values are hand-computed from the shift/saturate rule.
module tb_fixed_absmax_block_quantizer;

  logic              clk;
  logic              rst;
  logic signed [15:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic signed [7:0] data_out;
  logic [4:0]        data_out_exp;
  logic              data_out_last;
  logic              data_out_valid;
  logic              data_out_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int v [4];
  int q [4];

  fixed_absmax_block_quantizer #(
    .IN_WIDTH   (16),
    .OUT_WIDTH  (8),
    .BLOCK_SIZE (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_exp   (data_out_exp),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends v[0..3], then checks the SCALE gap and the four outputs against q[] and e.
  task automatic run_block(input string name, input int e, input int hold_idx);
    data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in       = 16'(v[i]);
      data_in_valid = 1'b1;
      check($sformatf("%s in_ready[%0d]", name, i), data_in_ready, 1);
      cycle();
    end
    data_in_valid = 1'b0;
    data_in       = '0;
    check({name, " scale_valid"}, data_out_valid, 0);
    check({name, " scale_in_ready"}, data_in_ready, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s valid[%0d]", name, i), data_out_valid, 1);
      check($sformatf("%s out[%0d]", name, i), data_out, q[i]);
      check($sformatf("%s exp[%0d]", name, i), data_out_exp, e);
      check($sformatf("%s last[%0d]", name, i), data_out_last, (i == 3) ? 1 : 0);
      check($sformatf("%s emit_in_ready[%0d]", name, i), data_in_ready, 0);
      if (i == hold_idx) begin
        data_out_ready = 1'b0;
        data_in_valid  = 1'b1;
        data_in        = 16'sh7fff;
        for (int k = 0; k < 3; k++) begin
          cycle();
          check($sformatf("%s hold%0d valid", name, k), data_out_valid, 1);
          check($sformatf("%s hold%0d out", name, k), data_out, q[i]);
          check($sformatf("%s hold%0d exp", name, k), data_out_exp, e);
          check($sformatf("%s hold%0d last", name, k), data_out_last, 0);
          check($sformatf("%s hold%0d in_ready", name, k), data_in_ready, 0);
        end
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_out_ready = 1'b1;
      end
      cycle();
    end
    check({name, " done_valid"}, data_out_valid, 0);
    check({name, " done_in_ready"}, data_in_ready, 1);
  endtask

  initial begin
    rst            = 1'b1;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    cycle();
    cycle();
    check("rst valid", data_out_valid, 0);
    check("rst out", data_out, 0);
    check("rst exp", data_out_exp, 0);
    check("rst last", data_out_last, 0);
    check("rst in_ready", data_in_ready, 0);
    rst = 1'b0;
    cycle();
    check("post_rst in_ready", data_in_ready, 1);

    // Block 1 with backpressure on the second element and ignored input during EMIT.
    v = '{1000, -3000, 20, 7};
    q = '{31, -94, 0, 0};
    run_block("blk_a", 5, 1);

    v = '{5, -3, 2, 1};
    q = '{5, -3, 2, 1};
    run_block("blk_b", 0, -1);

    v = '{-32768, 0, 0, 0};
    q = '{-64, 0, 0, 0};
    run_block("blk_c", 9, -1);

    // Abort a block after two elements.
    data_in_valid = 1'b1;
    data_in       = 16'sd30000;
    cycle();
    data_in       = -16'sd30000;
    cycle();
    data_in_valid = 1'b0;
    data_in       = '0;
    rst           = 1'b1;
    cycle();
    check("mid_rst valid", data_out_valid, 0);
    check("mid_rst out", data_out, 0);
    check("mid_rst exp", data_out_exp, 0);
    check("mid_rst in_ready", data_in_ready, 0);
    rst = 1'b0;
    cycle();
    check("mid_post_rst in_ready", data_in_ready, 1);

    v = '{100, 200, -50, 25};
    q = '{50, 100, -25, 12};
    run_block("blk_d", 1, -1);

    v = '{0, 0, 0, 0};
    q = '{0, 0, 0, 0};
    run_block("blk_e", 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
